// File: rtl/bcd_pkg.sv
// Shared types for the sequential binary-to-BCD converter and its digit adjuster.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  // Code the downstream 7-segment decoders render as all segments off
  localparam bcd_digit_t BCD_BLANK = 4'hF;

  typedef enum logic {
    IDLE,
    SHIFT
  } conv_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more, with no carry out.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t value,
  output bcd_digit_t adjusted
);

  assign adjusted = (value >= 4'd5) ? bcd_digit_t'(value + 4'd3) : value;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Shift-and-add-3 binary-to-BCD converter, one input bit per clock, with a start/busy/done handshake.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int          SW      = 4 * DIGITS;
  localparam int          CW      = $clog2(BIN_W + 1);
  localparam int unsigned MAX_VAL = 10 ** DIGITS - 1;

  conv_state_t        state;
  logic [CW-1:0]      cnt;
  logic [SW-1:0]      scratch;
  logic [BIN_W-1:0]   bin_sr;
  logic               ovf_pending;

  logic [SW-1:0]       adj;
  logic [SW+BIN_W-1:0] shifted;
  logic [SW-1:0]       scratch_next;
  logic [BIN_W-1:0]    bin_next;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_add3 u_add3 (
      .value    (scratch[4*i +: 4]),
      .adjusted (adj[4*i +: 4])
    );
  end

  // The adjusted scratch and the remaining binary bits move left together; the top bit falls off
  assign shifted      = {adj[SW-2:0], bin_sr, 1'b0};
  assign scratch_next = shifted[SW+BIN_W-1 -: SW];
  assign bin_next     = shifted[BIN_W-1:0];

  assign busy = (state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      scratch     <= '0;
      bin_sr      <= '0;
      ovf_pending <= 1'b0;
      bcd_out     <= {DIGITS{BCD_BLANK}};
      ovf         <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr      <= bin_in;
            ovf_pending <= (32'(bin_in) > MAX_VAL);
            scratch     <= '0;
            cnt         <= CW'(BIN_W);
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_next;
          bin_sr  <= bin_next;
          cnt     <= cnt - CW'(1);
          // Last bit: out-of-range values blank every digit regardless of the scratch contents
          if (cnt == CW'(1)) begin
            bcd_out <= ovf_pending ? {DIGITS{BCD_BLANK}} : scratch_next;
            ovf     <= ovf_pending;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq with hand-computed BCD results.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [15:0] bcd_out;

  int checks   = 0;
  int failures = 0;

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for done, reporting how many edges it took and how many busy-high samples were seen
  task automatic wait_done(output int edges, output int busy_cnt, output bit seen);
    edges    = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      edges++;
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: got no done, expected done within 40 cycles");
    end
  endtask

  // Starts one conversion, checks the handshake timing and the result
  task automatic apply_stimulus(input string tag, input logic [13:0] value,
                                input logic [15:0] exp_bcd, input logic exp_ovf);
    int  edges;
    int  busy_cnt;
    bit  seen;
    bin_in = value;
    start  = 1'b1;
    step();
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    wait_done(edges, busy_cnt, seen);
    busy_cnt += (busy_cnt > 0 && !seen) ? 0 : 1;
    if (seen) begin
      check_output({tag, "_latency"}, 32'(edges), 32'd14);
      check_output({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
      check_output({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
      step();
      check_output({tag, "_done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    int  edges;
    int  busy_cnt;
    int  done_cnt;
    bit  seen;

    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    #12;
    check_output("rst_bcd",  32'(bcd_out), 32'hFFFF);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_ovf",  32'(ovf), 32'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check_output("idle_bcd",  32'(bcd_out), 32'hFFFF);
    check_output("idle_busy", 32'(busy), 32'd0);

    // Main value with explicit busy-duration check
    bin_in = 14'd1234;
    start  = 1'b1;
    step();
    start = 1'b0;
    check_output("v1234_busy_start", 32'(busy), 32'd1);
    wait_done(edges, busy_cnt, seen);
    check_output("v1234_busy_cycles", 32'(busy_cnt + 1), 32'd14);
    check_output("v1234_latency", 32'(edges), 32'd14);
    check_output("v1234_bcd", 32'(bcd_out), 32'h1234);
    check_output("v1234_ovf", 32'(ovf), 32'd0);
    check_output("v1234_busy_end", 32'(busy), 32'd0);
    step();
    check_output("v1234_done_pulse", 32'(done), 32'd0);

    apply_stimulus("v0",     14'd0,     16'h0000, 1'b0);
    apply_stimulus("v9999",  14'd9999,  16'h9999, 1'b0);
    apply_stimulus("v10000", 14'd10000, 16'hFFFF, 1'b1);
    apply_stimulus("v16383", 14'd16383, 16'hFFFF, 1'b1);
    apply_stimulus("v7",     14'd7,     16'h0007, 1'b0);

    // A start pulse while busy must be dropped
    bin_in = 14'd500;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    bin_in = 14'd42;
    start  = 1'b1;
    step();
    start = 1'b0;
    wait_done(edges, busy_cnt, seen);
    check_output("busy_ignore_bcd", 32'(bcd_out), 32'h0500);
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done) done_cnt++;
    end
    check_output("busy_ignore_no_done", 32'(done_cnt), 32'd0);

    // Start held high: each value is captured on the edge that accepts it
    bin_in = 14'd1;
    start  = 1'b1;
    step();
    for (int i = 1; i <= 3; i++) begin
      wait_done(edges, busy_cnt, seen);
      check_output($sformatf("held%0d_interval", i), 32'(edges), (i == 1) ? 32'd14 : 32'd15);
      check_output($sformatf("held%0d_bcd", i), 32'(bcd_out), 32'(i));
      if (i < 3) bin_in = 14'(i + 1);
      else start = 1'b0;
    end
    step();
    check_output("held_stop_busy", 32'(busy), 32'd0);

    // Reset in the middle of a conversion aborts it
    bin_in = 14'd4321;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    rst_n = 1'b0;
    #1;
    check_output("abort_bcd",  32'(bcd_out), 32'hFFFF);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    step();
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done) done_cnt++;
    end
    check_output("abort_no_done", 32'(done_cnt), 32'd0);
    apply_stimulus("v88", 14'd88, 16'h0088, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It produces the packed BCD digit vector that the per-digit BCD-to-7-segment decoders consume. A start/busy/done handshake lets a counter or datapath request a conversion. Out-of-range values produce the blank code 4'hF on every digit, which the decoders render as all segments off.

Parameters:
BIN_W, 14, width of the binary input.
DIGITS, 4, number of BCD output digits; MAX_VAL = 10**DIGITS - 1.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  conversion request, sampled only in IDLE
bin_in  input  BIN_W  unsigned binary value, captured on accepted start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd_out/ovf update
ovf  output  1  last conversion had bin_in > MAX_VAL
bcd_out  output  4*DIGITS  packed BCD; digit 0 (units) in [3:0], digit k in [4k+3:4k]

Behaviour:
- Reset (async assert, sync release), all registers:
  - bcd_out = all digits 4'hF (blank); ovf = 0; busy = 0; done = 0.
  - state = IDLE; shift counter = 0; scratch = 0.
- States:
  - IDLE: start=1 at a rising edge captures bin_in into the shift register and sets ovf_pending = (bin_in > MAX_VAL). It also clears the 4*DIGITS BCD scratch, loads counter = BIN_W, and moves to SHIFT with busy=1.
  - SHIFT: each edge adds 3 to every scratch digit >= 5 (all digits adjusted in parallel), then shifts {scratch, binary} left by 1 and decrements the counter.
  - SHIFT, final edge (counter reaches 0): bcd_out <= ovf_pending ? all 4'hF : adjusted-and-shifted scratch. Also ovf <= ovf_pending, done <= 1, busy <= 0, state -> IDLE.
- Latency:
  - Start sampled at edge 0; done and the new bcd_out are visible in the cycle after edge BIN_W+... exactly edge BIN_W (15 cycles for the defaults, counting edge 0 as cycle 1).
  - busy is high from after edge 0 through edge BIN_W.
- done is high for exactly one cycle. bcd_out and ovf hold their value until the next done.
- start while busy is ignored, with no queuing.
- start in the same cycle done is high is accepted, because the state is already IDLE. Start held high gives back-to-back conversions every BIN_W+1 cycles.
- bin_in changes after capture have no effect.
- Scratch width is 4*DIGITS. On overflow the scratch bits shifted out are discarded; only ovf_pending decides the output.
- Arithmetic is unsigned throughout. The add-3 is 4-bit, applied only to digits >= 5, and never carries between digits.
- rst_n asserted mid-conversion aborts immediately: outputs return to reset values and no done is issued.

Decomposition:
- Package bcd_pkg contains:
  - typedef bcd_digit_t (logic [3:0]);
  - constant BCD_BLANK = 4'hF;
  - state enum conv_state_t {IDLE, SHIFT}.
- One natural combinational sub-module, bcd_add3: bcd_digit_t in, bcd_digit_t out, adds 3 when in >= 5. It is instantiated DIGITS times via generate.

Test Plan:
- Reset with rst_n=0 -> bcd_out=16'hFFFF, busy=0, done=0, ovf=0. The values hold with no start after release.
- bin_in=1234, 1-cycle start -> busy high for 14 cycles. Done pulses once, 15 cycles after start; bcd_out=16'h1234, ovf=0.
- Boundaries:
  - bin_in=0 -> 16'h0000.
  - bin_in=9999 -> 16'h9999, ovf=0.
  - bin_in=10000 -> 16'hFFFF, ovf=1.
  - bin_in=16383 -> 16'hFFFF, ovf=1.
  - Next conversion with bin_in=7 -> 16'h0007, ovf=0.
- Start with 500, pulse start with 42 at cycle 5 while busy -> result 16'h0500, then no further done.
- Start held high, bin_in=1, then 2, then 3, each changed in the cycle done pulses -> done every 15 cycles with bcd_out 0001, 0002, 0003, consistent with each value captured at its accepting edge.
- Start with 4321, drop rst_n at cycle 7 -> immediate bcd_out=16'hFFFF, busy=0, and no done. After release, start with 88 -> 16'h0088.
